// File: rtl/mips_mem_pkg.sv
// Shared types and address decode for the boot-ROM style instruction memory.
package mips_mem_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'hBFC0_0000;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_RESP
  } resp_state_e;

  function automatic logic imem_in_range(input word_t a);
    return a[31:10] == IMEM_BASE[31:10];
  endfunction

  // Aligned and inside the window: the only addresses that touch storage.
  function automatic logic imem_hit(input word_t a);
    return imem_in_range(a) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IMEM_AW-1:0] imem_index(input word_t a);
    return a[9:2];
  endfunction

endpackage

// File: rtl/imem_array.sv
// 256x32 instruction storage: one synchronous read port, one write port,
// read-before-write on a same-cycle collision.
module imem_array
  import mips_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rd_en,
  input  logic [IMEM_AW-1:0] rd_idx,
  output word_t              rd_data,
  input  logic               wr_en,
  input  logic [IMEM_AW-1:0] wr_idx,
  input  word_t              wr_data
);

  word_t mem_q [IMEM_DEPTH];
  word_t rd_data_q;

  // Contents are deliberately not reset so a preloaded program survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder in front of imem_array.
// Optional wait states: define INSTR_MEM_WAIT_EN to insert WAIT_CYCLES of latency.
module instr_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  input  logic        instr_read,
  output logic        instr_waitrequest,
  output logic        instr_rvalid,
  output logic [31:0] instr_readdata,
  output logic        instr_fault,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("WAIT_CYCLES must be in 0..15");
  end

  resp_state_e state_q, state_d;
  word_t       addr_q, addr_d;
  word_t       rd_data;
  logic        accept;
  logic        resp_hit;
  logic        resp_fault;

`ifdef INSTR_MEM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  assign accept = (state_q == RS_IDLE) && instr_read;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef INSTR_MEM_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      RS_IDLE: begin
        if (instr_read) begin
          addr_d = instr_address;
`ifdef INSTR_MEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            state_d = RS_RESP;
          end else begin
            state_d    = RS_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
`else
          state_d = RS_RESP;
`endif
        end
      end
`ifdef INSTR_MEM_WAIT_EN
      RS_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = RS_RESP;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
`endif
      RS_RESP: state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RS_IDLE;
      addr_q  <= '0;
`ifdef INSTR_MEM_WAIT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef INSTR_MEM_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // The word is read at acceptance and held by the array until RESP.
  imem_array u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (imem_index(instr_address)),
    .rd_data (rd_data),
    .wr_en   (prog_we && imem_hit(prog_addr)),
    .wr_idx  (imem_index(prog_addr)),
    .wr_data (prog_wdata)
  );

  // Address 0 is the CPU halt target: answered as a NOP, never a fault.
  assign resp_hit   = imem_hit(addr_q);
  assign resp_fault = !resp_hit && (addr_q != '0);

  assign instr_waitrequest = (state_q != RS_IDLE);
  assign instr_rvalid      = (state_q == RS_RESP);
  assign instr_fault       = instr_rvalid && resp_fault;
  assign instr_readdata    = (instr_rvalid && resp_hit) ? rd_data : '0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: table-driven fetches with a
// response scoreboard, plus collision, wait-state, reset and back-to-back sequences.
module tb_instr_mem_responder;

  localparam int unsigned TB_WAIT = 3;
`ifdef INSTR_MEM_WAIT_EN
  localparam int WAIT_EFF = TB_WAIT;
`else
  localparam int WAIT_EFF = 0;
`endif
  localparam int BOUND = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_address = '0;
  logic        instr_read = 1'b0;
  logic        instr_waitrequest;
  logic        instr_rvalid;
  logic [31:0] instr_readdata;
  logic        instr_fault;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0;

  instr_mem_responder #(.WAIT_CYCLES(TB_WAIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_address     (instr_address),
    .instr_read        (instr_read),
    .instr_waitrequest (instr_waitrequest),
    .instr_rvalid      (instr_rvalid),
    .instr_readdata    (instr_readdata),
    .instr_fault       (instr_fault),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_wdata        (prog_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] a, input logic [31:0] d, input logic f);
    exp_t e;
    e.addr = a; e.data = d; e.fault = f; e.due = cyc + 1 + WAIT_EFF;
    sb_q.push_back(e);
  endfunction

  // Response monitor: every rvalid must match the oldest outstanding fetch.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_rvalid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 at cyc %0d want no response", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("data@%h", mon_e.addr), 64'(instr_readdata), 64'(mon_e.data));
          chk($sformatf("fault@%h", mon_e.addr), 64'(instr_fault), 64'(mon_e.fault));
          chk($sformatf("latency@%h", mon_e.addr), 64'(cyc), 64'(mon_e.due));
        end
      end else begin
        chk("idle_outputs_zero", {31'b0, instr_fault, instr_readdata}, 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (instr_waitrequest !== 1'b0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout: got waitrequest=1 for %0d cycles want 0", n);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
    wait_idle();
    instr_read    = 1'b1;
    instr_address = a;
    push_exp(a, d, f);
    @(posedge clk); #1;
    instr_read = 1'b0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < BOUND) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    int acc;
    int k;
    vecs[0] = '{32'hBFC0_0000, 32'h2402_0005, 1'b0};
    vecs[1] = '{32'hBFC0_0004, 32'h8C43_0010, 1'b0};
    vecs[2] = '{32'hBFC0_03FC, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{32'hBFC0_0002, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0040_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'hBFC0_0400, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hBFBF_FFFC, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[9] = '{32'hBFC0_0001, 32'h0000_0000, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", 64'(instr_waitrequest), 64'd0);
    chk("reset_rvalid", 64'(instr_rvalid), 64'd0);
    chk("reset_readdata", 64'(instr_readdata), 64'd0);
    chk("reset_fault", 64'(instr_fault), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Preload; the last three writes are out of range or misaligned and must drop.
    prog(32'hBFC0_0000, 32'h2402_0005);
    prog(32'hBFC0_0004, 32'h8C43_0010);
    prog(32'hBFC0_0008, 32'h1111_1111);
    prog(32'hBFC0_03FC, 32'hCAFE_F00D);
    prog(32'hBFC0_0400, 32'hBAD0_BAD0);
    prog(32'hBFC0_0005, 32'hBAD1_BAD1);
    prog(32'h0000_0000, 32'hBAD2_BAD2);

    for (int i = 0; i < 10; i++) fetch(vecs[i].addr, vecs[i].data, vecs[i].fault);
    drain();

    // Same-cycle program write and fetch of one word returns the old word.
    wait_idle();
    prog_we = 1'b1; prog_addr = 32'hBFC0_0008; prog_wdata = 32'hDEAD_BEEF;
    instr_read = 1'b1; instr_address = 32'hBFC0_0008;
    push_exp(32'hBFC0_0008, 32'h1111_1111, 1'b0);
    @(posedge clk); #1;
    prog_we = 1'b0; instr_read = 1'b0;
    fetch(32'hBFC0_0008, 32'hDEAD_BEEF, 1'b0);
    drain();

    // Busy window length after one accepted fetch.
    wait_idle();
    instr_read = 1'b1; instr_address = 32'hBFC0_0004;
    push_exp(32'hBFC0_0004, 32'h8C43_0010, 1'b0);
    @(posedge clk); #1;
    instr_read = 1'b0;
    n = 0;
    repeat (WAIT_EFF + 3) begin
      @(negedge clk);
      if (instr_waitrequest === 1'b1) n++;
    end
    chk("waitrequest_cycles", 64'(n), 64'(WAIT_EFF + 1));
    drain();

    // Reset abandons an in-flight fetch without a response.
    wait_idle();
    instr_read = 1'b1; instr_address = 32'hBFC0_0000;
`ifdef INSTR_MEM_WAIT_EN
    @(posedge clk); #1;
    instr_read = 1'b0;
    @(negedge clk);
    chk("in_wait_waitrequest", 64'(instr_waitrequest), 64'd1);
    reset = 1'b1;
`else
    reset = 1'b1;
`endif
    @(posedge clk); #1;
    reset = 1'b0; instr_read = 1'b0;
    @(negedge clk);
    chk("post_reset_waitrequest", 64'(instr_waitrequest), 64'd0);
    chk("post_reset_rvalid", 64'(instr_rvalid), 64'd0);
    repeat (WAIT_EFF + 3) @(negedge clk);
    fetch(32'hBFC0_0000, 32'h2402_0005, 1'b0);
    fetch(32'hBFC0_03FC, 32'hCAFE_F00D, 1'b0);
    drain();

    // instr_read held high: one response per accepted request, none duplicated.
    wait_idle();
    instr_read = 1'b1;
    acc = 0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (instr_waitrequest === 1'b0) begin
        instr_address = vecs[k].addr;
        push_exp(vecs[k].addr, vecs[k].data, vecs[k].fault);
        k = (k + 1) % 10;
        acc++;
      end
    end
    @(posedge clk); #1;
    instr_read = 1'b0;
    chk("b2b_accepts", 64'(acc), 64'((12 + WAIT_EFF + 1) / (WAIT_EFF + 2)));
    drain();
    repeat (WAIT_EFF + 3) @(negedge clk);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instr_address  input  32  byte address of the fetch request.
REQ-005 instr_read  input  1  fetch request strobe.
REQ-006 instr_waitrequest  output  1  high = request not accepted this cycle.
REQ-007 instr_rvalid  output  1  one-cycle pulse: instr_readdata/instr_fault valid.
REQ-008 instr_readdata  output  32  fetched instruction word.
REQ-009 instr_fault  output  1  misaligned or out-of-range fetch, qualified by instr_rvalid.
REQ-010 prog_we / prog_addr / prog_wdata  input  1/32/32  bench preload write port, byte address decoded like instr_address.
REQ-011 Parameter WAIT_CYCLES, default 2, range 0..15, extra response latency in cycles.

Function
REQ-012 Window: base 0xBFC00000, 256 words; index = address[9:2]; in range when address[31:10] == base[31:10].
REQ-013 States: IDLE, WAIT, RESP; instr_waitrequest = (state != IDLE).
REQ-014 IDLE with instr_read=1 SHALL latch the address and go to RESP (or to WAIT when WAIT_CYCLES>0 per REQ-025); otherwise stay in IDLE.
REQ-015 RESP SHALL last exactly one cycle with instr_rvalid=1, then return to IDLE; maximum throughput is one fetch per 2 cycles with no wait states.
REQ-016 Without wait states, the request accepted at edge k SHALL produce instr_rvalid high in the cycle after edge k.
REQ-017 A fetch with address[1:0] != 0 or out of range SHALL respond with instr_fault=1 and instr_readdata=0.
REQ-018 Address 0x00000000 (the CPU halt target) SHALL respond with instr_readdata=0 (NOP) and instr_fault=0.
REQ-019 instr_readdata and instr_fault SHALL be 0 whenever instr_rvalid=0.
REQ-020 instr_read while instr_waitrequest=1 SHALL be ignored, not queued.
REQ-021 prog_we=1 with an in-range, aligned prog_addr SHALL write the word at the edge; otherwise the write is dropped silently.
REQ-022 A program write and a fetch of the same word in the same cycle SHALL return the old word (read-before-write).

Reset
REQ-023 Reset SHALL force IDLE, wait counter 0, instr_rvalid=0, instr_fault=0, instr_readdata=0, instr_waitrequest=0, and SHALL abandon any in-flight fetch without a response.
REQ-024 Reset SHALL NOT clear memory contents.

Configuration
REQ-025 With INSTR_MEM_WAIT_EN defined, acceptance SHALL enter WAIT for WAIT_CYCLES cycles (down-counter) before RESP, so instr_rvalid appears WAIT_CYCLES+1 cycles after acceptance; WAIT_CYCLES=0 skips WAIT.
REQ-026 Without INSTR_MEM_WAIT_EN, WAIT and its counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and latency SHALL be fixed at 1 cycle.

Structure
REQ-027 Package mips_mem_pkg SHALL hold IMEM_BASE, IMEM_DEPTH, the response-state enum typedef and the word typedef.
REQ-028 Storage SHALL be a sub-module imem_array: 256x32, one synchronous read port and one write port, read-before-write.

Verification
REQ-029 Preload 0x24020005 at 0xBFC00000; fetch 0xBFC00000 (no macro) -> next cycle rvalid=1, readdata=0x24020005, fault=0.
REQ-030 INSTR_MEM_WAIT_EN, WAIT_CYCLES=3; fetch 0xBFC00004 -> waitrequest high 4 cycles, rvalid on 4th cycle after acceptance.
REQ-031 Fetch 0xBFC00002 and 0x00400000 -> rvalid=1, fault=1, readdata=0; fetch 0x00000000 -> readdata=0, fault=0.
REQ-032 Same cycle: prog write 0xDEADBEEF to 0xBFC00008 while fetching 0xBFC00008 (old 0x11111111) -> 0x11111111; refetch -> 0xDEADBEEF.
REQ-033 Reset asserted in WAIT -> no rvalid, state IDLE, waitrequest=0 next cycle; refetch returns preloaded data intact.
REQ-034 instr_read held high continuously -> rvalid every 2nd cycle (no macro), one response per accepted request, none lost or duplicated.
